// File: rtl/serial_flow_alu_if.sv
// Handshake and serial bus bundle for serial_flow_alu.
// master drives operands and control; slave returns result bits and word flags.
interface serial_flow_alu_if;
    logic       start;
    logic [1:0] mode;
    logic       line1;
    logic       line2;
    logic       bit_valid;
    logic       outp;
    logic       outp_valid;
    logic       overflw;
    logic       cmp_gt;
    logic       cmp_eq;
    logic       done;
    logic       busy;

    modport master (
        output start, mode, line1, line2, bit_valid,
        input  outp, outp_valid, overflw, cmp_gt, cmp_eq, done, busy
    );

    modport slave (
        input  start, mode, line1, line2, bit_valid,
        output outp, outp_valid, overflw, cmp_gt, cmp_eq, done, busy
    );
endinterface

// File: rtl/serial_flow_alu.sv
// Serial LSB-first add/sub/compare engine over two bit streams.
// One word of WIDTH bits per start; bit_valid low stalls the word.
module serial_flow_alu #(
    parameter int WIDTH = 8
) (
    input logic              clock,
    input logic              reset,
    serial_flow_alu_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] count;
    logic [1:0]       mode_q;
    logic             carry;
    logic             gt_r;
    logic             eq_r;

    logic is_sub;
    logic is_cmp;
    logic b_eff;
    logic sum;
    logic cout;
    logic take;
    logic last;
    logic gt_n;
    logic eq_n;

    always_comb begin
        is_sub = (mode_q == 2'b01);
        is_cmp = mode_q[1];
        b_eff  = bus.line2 ^ is_sub;
        sum    = bus.line1 ^ b_eff ^ carry;
        cout   = (bus.line1 & b_eff) | (bus.line1 & carry) | (b_eff & carry);
        take   = (state == RUN) && bus.bit_valid;
        last   = take && (count == LAST);
        // A differing bit arrives at higher weight than all earlier ones
        gt_n   = (bus.line1 != bus.line2) ? bus.line1 : gt_r;
        eq_n   = eq_r & (bus.line1 == bus.line2);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (last)      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count          <= '0;
            mode_q         <= 2'b00;
            carry          <= 1'b0;
            gt_r           <= 1'b0;
            eq_r           <= 1'b0;
            bus.outp       <= 1'b0;
            bus.outp_valid <= 1'b0;
            bus.overflw    <= 1'b0;
            bus.cmp_gt     <= 1'b0;
            bus.cmp_eq     <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.outp_valid <= 1'b0;
            bus.done       <= 1'b0;
            if (state == IDLE && bus.start) begin
                mode_q <= bus.mode;
                count  <= '0;
                gt_r   <= 1'b0;
                eq_r   <= 1'b1;
                // Subtraction is A + ~B + 1
                carry  <= (bus.mode == 2'b01);
            end else if (take) begin
                bus.outp       <= is_cmp ? 1'b0 : sum;
                bus.outp_valid <= 1'b1;
                carry          <= cout;
                gt_r           <= gt_n;
                eq_r           <= eq_n;
                if (!last) count <= count + 1'b1;
                if (last) begin
                    bus.done    <= 1'b1;
                    bus.cmp_gt  <= gt_n;
                    bus.cmp_eq  <= eq_n;
                    bus.overflw <= is_cmp ? 1'b0 : (is_sub ? ~cout : cout);
                end
            end
        end
    end

    assign bus.busy = (state == RUN);
endmodule

// File: tb/tb_serial_flow_alu.sv
// Randomised and directed bench for serial_flow_alu at WIDTH=8.
// Expected words come from plain integer arithmetic on the operands.
module tb_serial_flow_alu;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    int          nbits;
    int          ndone;
    int          done_cyc;
    logic [63:0] obs_bits;
    logic        f_ovf, f_gt, f_eq, f_v;

    serial_flow_alu_if bus ();

    serial_flow_alu #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (bus.outp_valid) begin
            if (nbits < 64) obs_bits[nbits] = bus.outp;
            nbits++;
        end
        if (bus.done) begin
            ndone++;
            done_cyc = cyc;
            f_ovf = bus.overflw;
            f_gt  = bus.cmp_gt;
            f_eq  = bus.cmp_eq;
            f_v   = bus.outp_valid;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.outp, bus.outp_valid, bus.overflw, bus.cmp_gt,
                bus.cmp_eq, bus.done, bus.busy};
    endfunction

    // Called at posedge+1; returns at posedge+1.
    task automatic do_word(input logic [1:0] m, input logic [7:0] a,
                           input logic [7:0] b, input int st_a,
                           input int st_b, input bit rnd);
        logic [8:0] full;
        logic [7:0] res;
        logic       ovf;
        int         d0, scyc, tot, n, k;
        case (m)
            2'b00: begin
                full = {1'b0, a} + {1'b0, b};
                res  = full[7:0];
                ovf  = full[8];
            end
            2'b01: begin
                res = a - b;
                ovf = (a < b);
            end
            default: begin
                res = 8'h00;
                ovf = 1'b0;
            end
        endcase
        nbits = 0;
        obs_bits = '0;
        d0 = ndone;
        tot = 0;
        bus.start = 1'b1;
        bus.mode = m;
        @(posedge clock);
        #1;
        scyc = cyc;
        bus.start = 1'b0;
        for (int i = 0; i < W; i++) begin
            bus.line1 = a[i];
            bus.line2 = b[i];
            bus.bit_valid = 1'b1;
            if (rnd) bus.start = 1'($urandom);
            @(posedge clock);
            #1;
            bus.bit_valid = 1'b0;
            bus.line1 = 1'($urandom);
            bus.line2 = 1'($urandom);
            if (i < W - 1) begin
                if (rnd) n = int'($urandom % 3);
                else     n = (i == st_a || i == st_b) ? 3 : 0;
                repeat (n) begin
                    check("busy_stall", 64'(bus.busy), 64'd1);
                    @(posedge clock);
                    #1;
                end
                tot += n;
            end
        end
        bus.start = 1'b0;
        k = 0;
        while (ndone == d0 && k < 4) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("done_seen", 64'(ndone - d0), 64'd1);
        check("result", obs_bits, 64'(res));
        check("nbits", 64'(nbits), 64'(W));
        check("overflw", 64'(f_ovf), 64'(ovf));
        check("cmp_gt", 64'(f_gt), 64'(a > b));
        check("cmp_eq", 64'(f_eq), 64'(a == b));
        check("done_with_valid", 64'(f_v), 64'd1);
        check("latency", 64'(done_cyc - scyc), 64'(W + tot));
        @(posedge clock);
        #1;
        check("done_pulse", 64'({bus.done, bus.outp_valid, bus.busy}), 64'd0);
    endtask

    initial begin
        int d0;
        nbits = 0;
        ndone = 0;
        obs_bits = '0;
        bus.start = 1'b0;
        bus.mode = 2'b00;
        bus.line1 = 1'b0;
        bus.line2 = 1'b0;
        bus.bit_valid = 1'b0;
        #1;
        check("reset_outs", 64'(outs()), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_outs", 64'(outs()), 64'd0);

        do_word(2'b00, 8'hA5, 8'h3C, -1, -1, 1'b0);
        do_word(2'b00, 8'hFF, 8'h01, -1, -1, 1'b0);
        do_word(2'b01, 8'h10, 8'h20, -1, -1, 1'b0);
        do_word(2'b01, 8'h20, 8'h10, -1, -1, 1'b0);
        do_word(2'b10, 8'h80, 8'h7F, -1, -1, 1'b0);
        do_word(2'b10, 8'h5A, 8'h5A, -1, -1, 1'b0);
        do_word(2'b11, 8'h12, 8'h34, -1, -1, 1'b0);
        do_word(2'b00, 8'hA5, 8'h3C, 2, 5, 1'b0);

        // Abort a word after three bits
        d0 = ndone;
        bus.start = 1'b1;
        bus.mode = 2'b00;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.line1 = 1'b1;
            bus.line2 = 1'b1;
            bus.bit_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outs", 64'(outs()), 64'd0);
        bus.bit_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("no_done_on_abort", 64'(ndone - d0), 64'd0);
        check("idle_after_abort", 64'(outs()), 64'd0);
        do_word(2'b00, 8'hA5, 8'h3C, -1, -1, 1'b0);

        for (int t = 0; t < 20; t++) begin
            do_word(2'($urandom), 8'($urandom), 8'($urandom), -1, -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
